// File: rtl/key_debounce.sv
// Debounces and decodes one mechanical push-button: clean level plus
// single-cycle press, release and long-press events for control logic.
module key_debounce #(
  parameter logic [31:0] DEBOUNCE_CNT = 32'd4000000,
  parameter logic [31:0] LONG_CNT     = 32'd200000000,
  parameter logic        ACTIVE_LOW   = 1'b1
) (
  input  logic       sys_clk_high,
  input  logic       sys_rst_n,
  input  logic       key_in,
  output logic       key_level,
  output logic       key_press,
  output logic       key_release,
  output logic       key_long,
  output logic       key_held,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    PRESSED  = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_sync1;
  logic        r_sync2;
  logic        w_s;

  logic [31:0] r_db_cnt;
  logic [31:0] w_db_cnt_nxt;
  logic [31:0] r_lp_cnt;
  logic [31:0] w_lp_cnt_nxt;

  logic        r_level;
  logic        r_press;
  logic        r_release;
  logic        r_long;
  logic        r_held;

  logic        w_level_nxt;
  logic        w_press_nxt;
  logic        w_release_nxt;
  logic        w_long_nxt;
  logic        w_held_nxt;
  logic        w_in_db;
  logic        w_in_press;

  // Synchronizer idles at the released pad level so reset never looks like a press.
  always_ff @(posedge sys_clk_high or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1 <= ACTIVE_LOW;
      r_sync2 <= ACTIVE_LOW;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2 ^ ACTIVE_LOW;

  always_ff @(posedge sys_clk_high or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_s) w_state_nxt = PRESS_DB;
      end
      PRESS_DB: begin
        if (!w_s) begin
          w_state_nxt = IDLE;
        end else if (r_db_cnt == DEBOUNCE_CNT - 32'd1) begin
          w_state_nxt = PRESSED;
        end
      end
      PRESSED: begin
        if (!w_s) w_state_nxt = REL_DB;
      end
      REL_DB: begin
        if (w_s) begin
          w_state_nxt = PRESSED;
        end else if (r_db_cnt == DEBOUNCE_CNT - 32'd1) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_in_db       = (r_state == PRESS_DB) || (r_state == REL_DB);
    w_in_press    = (r_state == PRESSED)  || (r_state == REL_DB);
    w_press_nxt   = (r_state == PRESS_DB) && (w_state_nxt == PRESSED);
    w_release_nxt = (r_state == REL_DB)   && (w_state_nxt == IDLE);
    w_level_nxt   = (w_state_nxt == PRESSED) || (w_state_nxt == REL_DB);

    // The run counter only advances while a candidate state is held unchanged.
    w_db_cnt_nxt = 32'd0;
    if (w_in_db && (w_state_nxt == r_state)) begin
      w_db_cnt_nxt = r_db_cnt + 32'd1;
    end

    w_lp_cnt_nxt = r_lp_cnt;
    if ((w_state_nxt == IDLE) && (r_state != IDLE)) begin
      w_lp_cnt_nxt = 32'd0;
    end else if (w_in_press && (r_lp_cnt != LONG_CNT)) begin
      w_lp_cnt_nxt = r_lp_cnt + 32'd1;
    end

    // Saturation at LONG_CNT keeps this compare from matching twice in one press.
    w_long_nxt = w_in_press && !w_release_nxt && (r_lp_cnt == LONG_CNT - 32'd1);

    w_held_nxt = r_held;
    if (w_release_nxt) begin
      w_held_nxt = 1'b0;
    end else if (w_long_nxt) begin
      w_held_nxt = 1'b1;
    end
  end

  always_ff @(posedge sys_clk_high or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_db_cnt  <= 32'd0;
      r_lp_cnt  <= 32'd0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_db_cnt  <= w_db_cnt_nxt;
      r_lp_cnt  <= w_lp_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_long    <= w_long_nxt;
      r_held    <= w_held_nxt;
    end
  end

  assign key_level   = r_level;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign key_long    = r_long;
  assign key_held    = r_held;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus random key activity, checked
// against a run-length reference model through an expected-event queue.
module tb_key_debounce;

  localparam int D = 8;
  localparam int L = 40;

  logic       sys_clk_high = 1'b0;
  logic       sys_rst_n    = 1'b1;
  logic       key_in       = 1'b1;
  logic       key_level;
  logic       key_press;
  logic       key_release;
  logic       key_long;
  logic       key_held;
  logic [1:0] o_dbg_state;

  key_debounce #(
    .DEBOUNCE_CNT(32'd8),
    .LONG_CNT    (32'd40),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .sys_clk_high(sys_clk_high),
    .sys_rst_n   (sys_rst_n),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long),
    .key_held    (key_held),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  always #5 sys_clk_high = ~sys_clk_high;

  int n_checks = 0;
  int n_bad    = 0;

  // Reference model state: accepted level plus length of the run of samples
  // disagreeing with it; a run of D+1 flips the level.
  int   m_cyc   = 0;
  logic m_level = 1'b0;
  logic m_held  = 1'b0;
  int   m_run   = 0;
  int   m_lp    = 0;
  logic pipe_q[$] = '{1'b0, 1'b0};

  logic [34:0] exp_q[$];

  int n_press = 0, n_release = 0, n_long = 0;
  int last_press = -1, last_release = -1, last_long = -1;

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  task automatic model_step();
    logic       s;
    logic [2:0] ev;
    m_cyc++;
    ev = 3'b000;
    if (!sys_rst_n) begin
      pipe_q  = '{1'b0, 1'b0};
      m_level = 1'b0;
      m_held  = 1'b0;
      m_run   = 0;
      m_lp    = 0;
    end else begin
      s = pipe_q.pop_front();
      pipe_q.push_back(!key_in);
      if (s != m_level) m_run++;
      else m_run = 0;
      if (m_level) begin
        if (m_run == D + 1) begin
          m_level = 1'b0;
          m_run   = 0;
          m_lp    = 0;
          m_held  = 1'b0;
          ev[1]   = 1'b1;
        end else if (m_lp < L) begin
          m_lp++;
          if (m_lp == L) begin
            ev[2]  = 1'b1;
            m_held = 1'b1;
          end
        end
      end else if (m_run == D + 1) begin
        m_level = 1'b1;
        m_run   = 0;
        ev[0]   = 1'b1;
      end
      if (ev != 3'b000) exp_q.push_back({32'(m_cyc), ev});
    end
  endtask

  initial begin
    forever begin
      @(posedge sys_clk_high);
      model_step();
    end
  end

  // scoreboard monitor
  task automatic monitor_tick();
    logic [2:0]  ev;
    logic [34:0] e;
    ev = {key_long, key_release, key_press};
    check_int("level", int'(key_level), int'(m_level));
    check_int("held", int'(key_held), int'(m_held));
    while (exp_q.size() > 0 && int'(exp_q[0][34:3]) < m_cyc) begin
      e = exp_q.pop_front();
      check_int("missed_event_cycle", m_cyc, int'(e[34:3]));
    end
    if (exp_q.size() > 0 && int'(exp_q[0][34:3]) == m_cyc) begin
      e = exp_q.pop_front();
      check_int("event_bits", int'(ev), int'(e[2:0]));
    end else if (ev != 3'b000) begin
      check_int("unexpected_event", int'(ev), 0);
    end
    if (key_press)   begin n_press++;   last_press   = m_cyc; end
    if (key_release) begin n_release++; last_release = m_cyc; end
    if (key_long)    begin n_long++;    last_long    = m_cyc; end
  endtask

  initial begin
    forever begin
      @(posedge sys_clk_high);
      #1;
      monitor_tick();
    end
  end

  function automatic int get_cnt(input int sel);
    return (sel == 0) ? n_press : (sel == 1) ? n_release : n_long;
  endfunction

  function automatic int get_last(input int sel);
    return (sel == 0) ? last_press : (sel == 1) ? last_release : last_long;
  endfunction

  // driver tasks
  task automatic drive(input logic k, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk_high);
      key_in = k;
    end
  endtask

  task automatic set_key(input logic k, output int t);
    @(negedge sys_clk_high);
    key_in = k;
    t = m_cyc;
  endtask

  task automatic wait_evt(input int sel, input int budget, output int at);
    int start;
    start = get_cnt(sel);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge sys_clk_high);
      #2;
      if (get_cnt(sel) != start) begin
        at = get_last(sel);
        break;
      end
    end
  endtask

  initial begin
    int t0, t1, p, lg, r, c0, c1, len;

    // 1: reset with key released, then quiet idle
    #2 sys_rst_n = 1'b0;
    #1;
    check_int("reset_outputs", int'({key_level, key_press, key_release, key_long, key_held}), 0);
    check_int("reset_state", int'(o_dbg_state), 0);
    drive(1'b1, 5);
    @(negedge sys_clk_high);
    sys_rst_n = 1'b1;
    c0 = n_press + n_release + n_long;
    drive(1'b1, 100);
    check_int("idle_no_pulses", n_press + n_release + n_long - c0, 0);

    // 2: clean press and release latency
    set_key(1'b0, t0);
    wait_evt(0, 20, p);
    check_int("press_latency", p, t0 + 11);
    drive(1'b0, 9);
    check_int("level_pressed", int'(key_level), 1);
    set_key(1'b1, t1);
    wait_evt(1, 20, r);
    check_int("release_latency", r, t1 + 11);
    drive(1'b1, 20);

    // 3: bounce before settling
    c0 = n_press;
    drive(1'b0, 5);
    drive(1'b1, 2);
    set_key(1'b0, t0);
    drive(1'b0, 24);
    check_int("bounce_press_count", n_press - c0, 1);
    check_int("bounce_press_cycle", last_press, t0 + 11);
    set_key(1'b1, t1);
    drive(1'b1, 24);
    check_int("bounce_release_cycle", last_release, t1 + 11);

    // 4: long press
    set_key(1'b0, t0);
    wait_evt(0, 20, p);
    check_int("lp_press_cycle", p, t0 + 11);
    wait_evt(2, 60, lg);
    check_int("long_cycle", lg, p + 40);
    check_int("held_at_long", int'(key_held), 1);
    if (t0 + 60 - m_cyc > 0) drive(1'b0, t0 + 60 - m_cyc);
    check_int("held_before_release", int'(key_held), 1);
    set_key(1'b1, t1);
    wait_evt(1, 20, r);
    check_int("long_release_cycle", r, t1 + 11);
    check_int("held_cleared_at_release", int'(key_held), 0);
    drive(1'b1, 10);

    // 5: release glitch while pressed
    set_key(1'b0, t0);
    wait_evt(0, 20, p);
    c0 = n_press;
    c1 = n_release;
    drive(1'b0, 15);
    drive(1'b1, 5);
    drive(1'b0, 30);
    check_int("glitch_no_release", n_release - c1, 0);
    check_int("glitch_no_press", n_press - c0, 0);
    check_int("glitch_long_cycle", last_long, p + 40);
    check_int("glitch_level", int'(key_level), 1);

    // 6: reset mid-press with key still held
    c1 = n_release;
    @(negedge sys_clk_high);
    sys_rst_n = 1'b0;
    #1;
    check_int("midreset_outputs", int'({key_level, key_press, key_release, key_long, key_held}), 0);
    drive(1'b0, 3);
    @(negedge sys_clk_high);
    sys_rst_n = 1'b1;
    t0 = m_cyc;
    wait_evt(0, 20, p);
    check_int("repress_after_reset", p, t0 + 11);
    check_int("midreset_no_release", n_release - c1, 0);
    drive(1'b0, 5);

    // random key activity with occasional resets
    for (int seg = 0; seg < 80; seg++) begin
      if ($urandom_range(0, 19) == 0) begin
        @(negedge sys_clk_high);
        sys_rst_n = 1'b0;
        drive(key_in, int'($urandom_range(1, 3)));
        @(negedge sys_clk_high);
        sys_rst_n = 1'b1;
      end
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 90))
                                        : int'($urandom_range(1, 12));
      drive(1'($urandom_range(0, 1)), len);
    end

    drive(1'b1, 40);
    check_int("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
